// File: rtl/ahb_dma_copy.sv
// ahb_dma_copy: AHB-lite manager copying count elements src->dst, one read and one write per element, pipelined.
// Define AHB_DMA_FIXED_SRC_EN to add src_fixed (non-incrementing source for peripheral FIFO reads).
module ahb_dma_copy #(
  parameter int W_ADDR  = 32,
  parameter int W_DATA  = 32,
  parameter int W_COUNT = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [W_ADDR-1:0]  src_addr,
  input  logic [W_ADDR-1:0]  dst_addr,
  input  logic [W_COUNT-1:0] count,
  input  logic [1:0]         size,
`ifdef AHB_DMA_FIXED_SRC_EN
  input  logic               src_fixed,
`endif
  output logic               busy,
  output logic               done,
  output logic               err,
  input  logic               ahblm_hready,
  input  logic               ahblm_hresp,
  output logic [W_ADDR-1:0]  ahblm_haddr,
  output logic               ahblm_hwrite,
  output logic [1:0]         ahblm_htrans,
  output logic [2:0]         ahblm_hsize,
  output logic [2:0]         ahblm_hburst,
  output logic [3:0]         ahblm_hprot,
  output logic               ahblm_hmastlock,
  output logic [W_DATA-1:0]  ahblm_hwdata,
  input  logic [W_DATA-1:0]  ahblm_hrdata
);
  typedef enum logic [2:0] {IDLE, RD_A, RD_D_WR_A, WR_D_RD_A, WR_D_LAST, ERR} state_t;
  state_t r_state, w_next;
  logic [W_ADDR-1:0] r_src, r_dst, w_step, w_src_step, w_mask;
  logic [W_COUNT-1:0] r_rem;
  logic [1:0] r_size;
  logic [W_DATA-1:0] r_wdata, w_shifted, w_lanes;
  logic r_done, r_err;
  logic w_go, w_data_ph, w_err_hit, w_cap, w_finish;
  assign w_go      = (r_state == IDLE) && start;
  assign w_data_ph = (r_state == RD_D_WR_A) || (r_state == WR_D_RD_A) || (r_state == WR_D_LAST);
  // first error cycle (hready low) already aborts so the pending address phase is never accepted
  assign w_err_hit = w_data_ph && ahblm_hresp && !ahblm_hready;
  assign w_cap     = (r_state == RD_D_WR_A) && ahblm_hready;
  assign w_finish  = ahblm_hready && ((r_state == WR_D_LAST) || (r_state == ERR));
  assign w_step    = W_ADDR'(1) << r_size;
  assign w_mask    = ~((W_ADDR'(1) << size) - W_ADDR'(1));
  assign w_shifted = ahblm_hrdata >> {r_src[1:0], 3'b000};
  assign w_lanes   = (r_size == 2'd0) ? {(W_DATA/8){w_shifted[7:0]}} :
                     (r_size == 2'd1) ? {(W_DATA/16){w_shifted[15:0]}} : w_shifted;
`ifdef AHB_DMA_FIXED_SRC_EN
  logic r_fixed;
  always_ff @(posedge clk)
    if (!rst_n) r_fixed <= 1'b0;
    else if (w_go) r_fixed <= src_fixed;
  assign w_src_step = r_fixed ? '0 : w_step;
`else
  assign w_src_step = w_step;
`endif
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:      w_next = (start && count != '0) ? RD_A : IDLE;
      RD_A:      w_next = ahblm_hready ? RD_D_WR_A : RD_A;
      RD_D_WR_A: w_next = w_err_hit ? ERR : !ahblm_hready ? RD_D_WR_A :
                          (r_rem == W_COUNT'(1)) ? WR_D_LAST : WR_D_RD_A;
      WR_D_RD_A: w_next = w_err_hit ? ERR : ahblm_hready ? RD_D_WR_A : WR_D_RD_A;
      WR_D_LAST: w_next = w_err_hit ? ERR : ahblm_hready ? IDLE : WR_D_LAST;
      ERR:       w_next = ahblm_hready ? IDLE : ERR;
      default:   w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_src   <= '0;
      r_dst   <= '0;
      r_rem   <= '0;
      r_size  <= '0;
      r_wdata <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= w_finish || (w_go && count == '0);
      if (w_go) begin
        r_src  <= src_addr & w_mask;
        r_dst  <= dst_addr & w_mask;
        r_rem  <= count;
        r_size <= size;
        r_err  <= 1'b0;
      end
      if (w_cap) begin
        r_wdata <= w_lanes;
        r_rem   <= r_rem - W_COUNT'(1);
        r_src   <= r_src + w_src_step;
        r_dst   <= r_dst + w_step;
      end
      if ((r_state == ERR) && ahblm_hready) r_err <= 1'b1;
    end
  end
  assign busy            = r_state != IDLE;
  assign done            = r_done;
  assign err             = r_err;
  assign ahblm_haddr     = (r_state == RD_D_WR_A) ? r_dst : r_src;
  assign ahblm_hwrite    = r_state == RD_D_WR_A;
  assign ahblm_htrans    = ((r_state == RD_A) || (r_state == RD_D_WR_A) || (r_state == WR_D_RD_A)) ? 2'b10 : 2'b00;
  assign ahblm_hsize     = {1'b0, r_size};
  assign ahblm_hburst    = 3'b000;
  assign ahblm_hprot     = 4'b0011;
  assign ahblm_hmastlock = 1'b0;
  assign ahblm_hwdata    = r_wdata;
endmodule

// File: tb/tb_ahb_dma_copy.sv
// tb_ahb_dma_copy: AHB subordinate/memory model plus byte-level copy reference for ahb_dma_copy.
module tb_ahb_dma_copy;
  logic clk = 0, rst_n = 0, start = 0;
  logic [31:0] src_addr = 0, dst_addr = 0;
  logic [15:0] count = 0;
  logic [1:0] size = 0;
`ifdef AHB_DMA_FIXED_SRC_EN
  logic src_fixed = 0;
`endif
  logic busy, done, err;
  logic hready = 1, hresp = 0;
  logic [31:0] haddr, hwdata, hrdata = 0;
  logic hwrite, hmastlock;
  logic [1:0] htrans;
  logic [2:0] hsize, hburst;
  logic [3:0] hprot;
  always #5 clk = ~clk;
  ahb_dma_copy #(.W_ADDR(32), .W_DATA(32), .W_COUNT(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
    .count(count), .size(size),
`ifdef AHB_DMA_FIXED_SRC_EN
    .src_fixed(src_fixed),
`endif
    .busy(busy), .done(done), .err(err), .ahblm_hready(hready), .ahblm_hresp(hresp),
    .ahblm_haddr(haddr), .ahblm_hwrite(hwrite), .ahblm_htrans(htrans), .ahblm_hsize(hsize),
    .ahblm_hburst(hburst), .ahblm_hprot(hprot), .ahblm_hmastlock(hmastlock),
    .ahblm_hwdata(hwdata), .ahblm_hrdata(hrdata)
  );
  typedef struct packed {logic [31:0] a; logic [31:0] d; logic [2:0] sz;} xfer_t;
  typedef struct {logic [31:0] s; logic [31:0] d; int n; logic [1:0] sz; int w; int lat; int nwr; logic [31:0] last_wa; logic [31:0] last_wd;} vec_t;
  logic [7:0] mem [bit [31:0]];
  xfer_t rd_q[$], wr_q[$];
  int n_chk = 0, n_fail = 0;
  int waits = 0, err_idx = -1, rd_cnt = 0, nonseq_cnt = 0, stab_bad = 0;
  logic err2_seen = 0;
  logic [1:0] err2_htrans = 0;
  logic ph_v = 0, ph_w = 0, ph_e = 0;
  logic [31:0] ph_a = 0;
  logic [2:0] ph_s = 0;
  int ph_c = 0;
  logic p_rdy = 1, p_resp = 0, p_write = 0;
  logic [31:0] p_addr = 0, p_wdata = 0;
  logic [1:0] p_trans = 0;
  int lat;
  logic e_done, b_done, e_start, d_after;
  function automatic logic [7:0] rdb(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : (a[7:0] ^ 8'h5A);
  endfunction
  task automatic put_word(input logic [31:0] a, input logic [31:0] w);
    for (int b = 0; b < 4; b++) mem[a + 32'(b)] = w[8*b +: 8];
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic tick;
    @(negedge clk);
    #1;
  endtask
  // subordinate: decides hready/hresp for the pending data phase, then retires it and accepts the next address phase
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      ph_v = 0; hready = 1; hresp = 0; p_rdy = 1; p_resp = 0;
    end else begin
      hready = ph_v ? (ph_e ? (ph_c >= 1) : (ph_c >= waits)) : 1'b1;
      hresp  = ph_v && ph_e;
      hrdata = (ph_v && !ph_w) ? {rdb({ph_a[31:2], 2'd3}), rdb({ph_a[31:2], 2'd2}), rdb({ph_a[31:2], 2'd1}), rdb({ph_a[31:2], 2'd0})} : $urandom;
      if (ph_v && ph_e && ph_c == 1) begin err2_seen = 1; err2_htrans = htrans; end
      if (!p_rdy && !p_resp && {haddr, htrans, hwrite} != {p_addr, p_trans, p_write}) stab_bad++;
      if (!p_rdy && hwdata != p_wdata) stab_bad++;
      p_rdy = hready; p_resp = hresp; p_addr = haddr; p_trans = htrans; p_write = hwrite; p_wdata = hwdata;
      ph_c++;
      if (hready) begin
        if (ph_v && ph_w && !ph_e) begin
          for (int b = 0; b < (1 << ph_s); b++) mem[ph_a + 32'(b)] = hwdata[8*((32'(ph_a[1:0]) + b) % 4) +: 8];
          wr_q.push_back('{ph_a, hwdata, ph_s});
        end
        ph_v = htrans == 2'b10;
        if (ph_v) begin
          ph_a = haddr; ph_w = hwrite; ph_s = hsize; ph_c = 0; nonseq_cnt++;
          ph_e = !hwrite && rd_cnt == err_idx;
          if (!hwrite) begin rd_q.push_back('{haddr, 32'h0, hsize}); rd_cnt++; end
        end
      end
    end
  end
  task automatic do_copy(input logic [31:0] s, input logic [31:0] d, input int n, input logic [1:0] sz, input int w, input int eidx, input int poke);
    waits = w; err_idx = eidx; rd_cnt = 0; nonseq_cnt = 0; err2_seen = 0; err2_htrans = 2'b11;
    rd_q.delete(); wr_q.delete();
    src_addr = s; dst_addr = d; count = 16'(n); size = sz; start = 1;
    tick;
    start = 0;
    e_start = err;
    lat = 0;
    while (!done && lat < 3000) begin
      if (lat == poke) begin
        start = 1; src_addr = 32'hDEAD_0000; dst_addr = 32'hBEEF_0000; count = 16'd1; size = 2'd0;
      end
      tick;
      start = 0;
      lat++;
    end
    if (!done) chk("done timeout", {31'b0, done}, 32'd1);
    e_done = err; b_done = busy;
    tick;
    d_after = done;
  endtask
  task automatic check_copy(input string nm, input logic [31:0] s, input logic [31:0] d, input int n, input logic [1:0] sz, input bit fx);
    int st;
    logic [31:0] ra, wa, e, ew, dw;
    st = 1 << sz;
    chk({nm, " rd count"}, 32'(rd_q.size()), 32'(n));
    chk({nm, " wr count"}, 32'(wr_q.size()), 32'(n));
    for (int i = 0; i < n && i < rd_q.size() && i < wr_q.size(); i++) begin
      ra = (s & ~32'(st - 1)) + (fx ? 32'd0 : 32'(i * st));
      wa = (d & ~32'(st - 1)) + 32'(i * st);
      e = 0; dw = 0;
      for (int b = 0; b < st; b++) begin
        e[8*b +: 8] = rdb(ra + 32'(b));
        dw[8*b +: 8] = rdb(wa + 32'(b));
      end
      ew = (sz == 2'd0) ? {4{e[7:0]}} : (sz == 2'd1) ? {2{e[15:0]}} : e;
      chk($sformatf("%s rd%0d addr", nm, i), rd_q[i].a, ra);
      chk($sformatf("%s rd%0d hsize", nm, i), 32'(rd_q[i].sz), 32'(sz));
      chk($sformatf("%s wr%0d addr", nm, i), wr_q[i].a, wa);
      chk($sformatf("%s wr%0d hsize", nm, i), 32'(wr_q[i].sz), 32'(sz));
      chk($sformatf("%s wr%0d hwdata", nm, i), wr_q[i].d, ew);
      chk($sformatf("%s dst%0d mem", nm, i), dw, e);
    end
  endtask
  initial begin
    vec_t tv[3];
    int cnt_d;
    tv[0] = '{32'h100, 32'h200, 4, 2'd2, 0, 9, 4, 32'h20C, 32'h0BAD_F00D};
    tv[1] = '{32'h101, 32'h302, 2, 2'd0, 0, 5, 2, 32'h303, 32'hBBBB_BBBB};
    tv[2] = '{32'h500, 32'h700, 3, 2'd2, 2, 19, 3, 32'h708, 32'hCAFE_F00D};
    put_word(32'h100, 32'hDEAD_BEEF); put_word(32'h104, 32'h0102_0304);
    put_word(32'h108, 32'hA5A5_5A5A); put_word(32'h10C, 32'h0BAD_F00D);
    mem[32'h101] = 8'hAA; mem[32'h102] = 8'hBB;
    put_word(32'h508, 32'hCAFE_F00D);
    put_word(32'h400, 32'h1357_9BDF);
    repeat (3) tick;
    chk("rst busy", {31'b0, busy}, 0);
    chk("rst done", {31'b0, done}, 0);
    chk("rst err", {31'b0, err}, 0);
    chk("rst htrans", {30'b0, htrans}, 0);
    chk("rst haddr", haddr, 0);
    chk("rst hwrite", {31'b0, hwrite}, 0);
    chk("rst hwdata", hwdata, 0);
    chk("hburst", {29'b0, hburst}, 0);
    chk("hprot", {28'b0, hprot}, 32'h3);
    chk("hmastlock", {31'b0, hmastlock}, 0);
    rst_n = 1;
    tick;
    for (int k = 0; k < 3; k++) begin
      do_copy(tv[k].s, tv[k].d, tv[k].n, tv[k].sz, tv[k].w, -1, -1);
      chk($sformatf("tv%0d latency", k), 32'(lat), 32'(tv[k].lat));
      chk($sformatf("tv%0d err", k), {31'b0, e_done}, 0);
      chk($sformatf("tv%0d busy at done", k), {31'b0, b_done}, 0);
      chk($sformatf("tv%0d done pulse", k), {31'b0, d_after}, 0);
      chk($sformatf("tv%0d nwr", k), 32'(wr_q.size()), 32'(tv[k].nwr));
      if (wr_q.size() > 0) begin
        chk($sformatf("tv%0d last waddr", k), wr_q[$].a, tv[k].last_wa);
        chk($sformatf("tv%0d last wdata", k), wr_q[$].d, tv[k].last_wd);
      end
      chk($sformatf("tv%0d stability", k), 32'(stab_bad), 0);
      check_copy($sformatf("tv%0d", k), tv[k].s, tv[k].d, tv[k].n, tv[k].sz, 1'b0);
    end
    do_copy(32'h400, 32'h900, 4, 2'd2, 0, 1, -1);
    chk("err latency", 32'(lat), 5);
    chk("err flag", {31'b0, e_done}, 1);
    chk("err busy at done", {31'b0, b_done}, 0);
    chk("err nwr", 32'(wr_q.size()), 1);
    if (wr_q.size() > 0) chk("err wr0 data", wr_q[0].d, 32'h1357_9BDF);
    chk("err no 2nd write", {31'b0, mem.exists(32'h904)}, 0);
    chk("err 2nd cycle seen", {31'b0, err2_seen}, 1);
    chk("err 2nd cycle htrans", {30'b0, err2_htrans}, 0);
    chk("err nonseq total", 32'(nonseq_cnt), 3);
    repeat (3) tick;
    chk("err held", {31'b0, err}, 1);
    do_copy(32'h100, 32'hA00, 1, 2'd2, 0, -1, -1);
    chk("err cleared on start", {31'b0, e_start}, 0);
    chk("good after err", {31'b0, e_done}, 0);
    do_copy(32'h100, 32'hB00, 0, 2'd2, 0, -1, -1);
    chk("cnt0 done next cycle", 32'(lat), 0);
    chk("cnt0 err", {31'b0, e_done}, 0);
    repeat (3) tick;
    chk("cnt0 no nonseq", 32'(nonseq_cnt), 0);
    do_copy(32'h100, 32'h600, 4, 2'd2, 0, -1, 2);
    chk("poke latency", 32'(lat), 9);
    check_copy("poke", 32'h100, 32'h600, 4, 2'd2, 1'b0);
    src_addr = 32'h100; dst_addr = 32'hC00; count = 16'd4; size = 2'd2; start = 1;
    tick;
    start = 0;
    repeat (3) tick;
    rst_n = 0;
    tick;
    chk("midrst busy", {31'b0, busy}, 0);
    chk("midrst htrans", {30'b0, htrans}, 0);
    chk("midrst done", {31'b0, done}, 0);
    rst_n = 1;
    cnt_d = 0;
    repeat (10) begin tick; cnt_d += 32'(done); end
    chk("midrst no done", 32'(cnt_d), 0);
`ifdef AHB_DMA_FIXED_SRC_EN
    put_word(32'h4000_0000, 32'h7766_5544);
    src_fixed = 1;
    do_copy(32'h4000_0000, 32'hD00, 3, 2'd2, 0, -1, -1);
    src_fixed = 0;
    chk("fixed latency", 32'(lat), 7);
    check_copy("fixed", 32'h4000_0000, 32'hD00, 3, 2'd2, 1'b1);
`endif
    for (int it = 0; it < 20; it++) begin
      logic [31:0] s, d;
      int n, w;
      logic [1:0] sz;
      for (int a = 32'h1000; a < 32'h1120; a++) mem[32'(a)] = 8'($urandom);
      sz = 2'($urandom_range(0, 2));
      n = $urandom_range(1, 6);
      w = $urandom_range(0, 2);
      s = 32'h1000 + 32'($urandom_range(0, 255));
      d = 32'h8000 + 32'($urandom_range(0, 255));
      do_copy(s, d, n, sz, w, -1, -1);
      chk($sformatf("rnd%0d latency", it), 32'(lat), 32'(2 * n + 1 + 2 * n * w));
      chk($sformatf("rnd%0d err", it), {31'b0, e_done}, 0);
      check_copy($sformatf("rnd%0d", it), s, d, n, sz, 1'b0);
    end
    chk("stability final", 32'(stab_bad), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
